// File: rtl/btb_update_queue_pkg.sv
// Shared RV32I commit/BTB types: the BTB training bus and the queued update entry.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_branch_address;
    logic        branch_inst;
    logic        jal_inst;
    logic        branch_resol;
    logic        valid;
    logic        ready;
  } rob_to_btb_bus;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_branch_address;
    logic        branch_inst;
    logic        jal_inst;
    logic        branch_resol;
  } btb_upd_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/btb_update_queue_fifo.sv
// Synchronous FIFO of BTB update entries; head is read combinationally, no bypass.
// Push is ignored when full and pop when empty; the caller is expected to honour both flags.
module btb_upd_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BITS  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  btb_upd_entry_t wr_dat,
  input  logic           pop,
  output btb_upd_entry_t rd_dat,
  output logic           full,
  output logic           empty
);

  localparam logic [BITS:0] PTR_ONE = 1;

  btb_upd_entry_t mem [DEPTH];
  logic [BITS:0]  wr_ptr;
  logic [BITS:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra MSB distinguishes full from empty when the indices coincide.
  assign full    = (wr_ptr[BITS-1:0] == rd_ptr[BITS-1:0]) && (wr_ptr[BITS] != rd_ptr[BITS]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_dat  = mem[rd_ptr[BITS-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[BITS-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/btb_update_queue.sv
// Commit-side BTB trainer: queues retired branches/JALs (1-cycle push-to-visible), drains one per btb_en cycle,
// stalls the ROB via commit_ready only when full; flags mispredicts with a registered redirect pulse.
module btb_update_queue
  import rv32i_types::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned QUEUE_BITS  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          commit_valid,
  output logic          commit_ready,
  input  logic [31:0]   commit_pc,
  input  logic          commit_is_branch,
  input  logic          commit_is_jal,
  input  logic          commit_taken,
  input  logic [31:0]   commit_target,
  input  logic          commit_pred_taken,
  input  logic [31:0]   commit_pred_target,
  input  logic          btb_en,
  output rob_to_btb_bus btb_update,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc,
  output logic [31:0]   branch_count,
  output logic [31:0]   mispred_count
);

  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           act_taken;
  logic           mispred;
  logic [31:0]    next_pc;
  btb_upd_entry_t push_entry;
  btb_upd_entry_t head_entry;

  // Ready depends on occupancy only, so the ROB never sees a path from btb_en.
  assign commit_ready = !fifo_full;
  assign push         = commit_valid && commit_ready && (commit_is_branch || commit_is_jal);
  assign pop          = !fifo_empty && btb_en;
  assign act_taken    = commit_is_jal | commit_taken;
  assign next_pc      = act_taken ? commit_target : commit_pc + PC_STEP;

  always_comb begin
    mispred = 1'b0;
    if (commit_is_jal) begin
      mispred = !commit_pred_taken || (commit_target != commit_pred_target);
    end else if (commit_is_branch) begin
      mispred = (commit_taken != commit_pred_taken) ||
                (commit_taken && commit_pred_taken && (commit_target != commit_pred_target));
    end
  end

  always_comb begin
    push_entry                     = '0;
    push_entry.pc                  = commit_pc;
    push_entry.pred_branch_address = commit_target;
    push_entry.branch_inst         = commit_is_branch;
    push_entry.jal_inst            = commit_is_jal;
    push_entry.branch_resol        = act_taken;
  end

  btb_upd_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .BITS  (QUEUE_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wr_dat (push_entry),
    .pop    (pop),
    .rd_dat (head_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    btb_update                     = '0;
    btb_update.pc                  = head_entry.pc;
    btb_update.pred_branch_address = head_entry.pred_branch_address;
    btb_update.branch_inst         = head_entry.branch_inst;
    btb_update.jal_inst            = head_entry.jal_inst;
    btb_update.branch_resol        = head_entry.branch_resol;
    btb_update.valid               = !fifo_empty;
    btb_update.ready               = btb_en;
  end

  // redirect_pc holds its last value between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      branch_count   <= '0;
      mispred_count  <= '0;
    end else begin
      redirect_valid <= push && mispred;
      if (push) begin
        branch_count <= branch_count + 32'd1;
        if (mispred) begin
          redirect_pc   <= next_pc;
          mispred_count <= mispred_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: queue-based reference model checked every cycle plus literal checkpoints.
module tb_btb_update_queue;
  import rv32i_types::*;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          commit_valid = 1'b0;
  logic          commit_ready;
  logic [31:0]   commit_pc = '0;
  logic          commit_is_branch = 1'b0;
  logic          commit_is_jal = 1'b0;
  logic          commit_taken = 1'b0;
  logic [31:0]   commit_target = '0;
  logic          commit_pred_taken = 1'b0;
  logic [31:0]   commit_pred_target = '0;
  logic          btb_en = 1'b0;
  rob_to_btb_bus btb_update;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   branch_count;
  logic [31:0]   mispred_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btb_update_queue #(.QUEUE_DEPTH(4), .QUEUE_BITS(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .commit_valid       (commit_valid),
    .commit_ready       (commit_ready),
    .commit_pc          (commit_pc),
    .commit_is_branch   (commit_is_branch),
    .commit_is_jal      (commit_is_jal),
    .commit_taken       (commit_taken),
    .commit_target      (commit_target),
    .commit_pred_taken  (commit_pred_taken),
    .commit_pred_target (commit_pred_target),
    .btb_en             (btb_en),
    .btb_update         (btb_update),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .branch_count       (branch_count),
    .mispred_count      (mispred_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of committed control instructions.
  btb_upd_entry_t mq[$];
  logic [31:0]    m_bc = '0;
  logic [31:0]    m_mc = '0;
  logic [31:0]    m_rpc = '0;
  logic           m_rv = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    bit             do_pop;
    bit             do_push;
    bit             act_taken;
    bit             mis;
    btb_upd_entry_t e;
    if (!rst) begin
      mq.delete();
      m_bc  = '0;
      m_mc  = '0;
      m_rpc = '0;
      m_rv  = 1'b0;
    end else begin
      do_pop    = (mq.size() != 0) && btb_en;
      do_push   = commit_valid && (mq.size() < DEPTH) && (commit_is_branch || commit_is_jal);
      act_taken = commit_is_jal || commit_taken;
      mis       = (act_taken != commit_pred_taken) ||
                  (act_taken && (commit_target != commit_pred_target));
      m_rv = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc                  = commit_pc;
        e.pred_branch_address = commit_target;
        e.branch_inst         = commit_is_branch;
        e.jal_inst            = commit_is_jal;
        e.branch_resol        = act_taken;
        mq.push_back(e);
        m_bc = m_bc + 32'd1;
        if (mis) begin
          m_mc  = m_mc + 32'd1;
          m_rv  = 1'b1;
          m_rpc = act_taken ? commit_target : commit_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    #2;
    chk("m_ready", commit_ready, mq.size() < DEPTH);
    chk("m_valid", btb_update.valid, mq.size() != 0);
    chk("m_btb_ready", btb_update.ready, btb_en);
    if (mq.size() != 0) begin
      chk("m_pc", btb_update.pc, mq[0].pc);
      chk("m_addr", btb_update.pred_branch_address, mq[0].pred_branch_address);
      chk("m_br", btb_update.branch_inst, mq[0].branch_inst);
      chk("m_jal", btb_update.jal_inst, mq[0].jal_inst);
      chk("m_resol", btb_update.branch_resol, mq[0].branch_resol);
    end
    chk("m_rv", redirect_valid, m_rv);
    chk("m_rpc", redirect_pc, m_rpc);
    chk("m_bc", branch_count, m_bc);
    chk("m_mc", mispred_count, m_mc);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #3;
  endtask

  task automatic drive(input logic br, input logic jal, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    commit_valid       = 1'b1;
    commit_is_branch   = br;
    commit_is_jal      = jal;
    commit_pc          = pc;
    commit_taken       = taken;
    commit_target      = tgt;
    commit_pred_taken  = pt;
    commit_pred_target = ptgt;
  endtask

  task automatic idle();
    commit_valid     = 1'b0;
    commit_is_branch = 1'b0;
    commit_is_jal    = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_ready", commit_ready, 1);
    chk("rst_valid", btb_update.valid, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_bc", branch_count, 0);
    chk("rst_mc", mispred_count, 0);
    @(negedge clk);
    #3;
    rst    = 1'b1;
    btb_en = 1'b1;

    // Correctly predicted taken branch.
    drive(1, 0, 32'h1000, 1, 32'h1040, 1, 32'h1040);
    tick();
    idle();
    chk("t1_valid", btb_update.valid, 1);
    chk("t1_pc", btb_update.pc, 32'h1000);
    chk("t1_addr", btb_update.pred_branch_address, 32'h1040);
    chk("t1_resol", btb_update.branch_resol, 1);
    chk("t1_rv", redirect_valid, 0);
    chk("t1_bc", branch_count, 1);
    chk("t1_mc", mispred_count, 0);

    // Direction mispredict: predicted taken, resolved not taken.
    drive(1, 0, 32'h2000, 0, 32'h2100, 1, 32'h2100);
    tick();
    idle();
    chk("t2_rv", redirect_valid, 1);
    chk("t2_rpc", redirect_pc, 32'h2004);
    chk("t2_mc", mispred_count, 1);
    chk("t2_bc", branch_count, 2);
    chk("t2_pc", btb_update.pc, 32'h2000);
    chk("t2_resol", btb_update.branch_resol, 0);
    tick();
    chk("t2_pulse_end", redirect_valid, 0);
    chk("t2_empty", btb_update.valid, 0);

    // Fill to full with JALs while the BTB port is busy.
    btb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'h10 * (i + 1), 0, 32'h400 + 32'h10 * i, 1, 32'h400 + 32'h10 * i);
      tick();
    end
    chk("t3_full", commit_ready, 0);
    drive(0, 1, 32'h50, 0, 32'h500, 1, 32'h500);
    tick();
    tick();
    idle();
    chk("t3_stall_bc", branch_count, 6);
    chk("t3_stall_ready", commit_ready, 0);
    btb_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_pc", btb_update.pc, 32'h10 * (i + 1));
      chk("t3_drain_jal", btb_update.jal_inst, 1);
      tick();
      if (i == 0) chk("t3_ready_back", commit_ready, 1);
    end
    chk("t3_drained", btb_update.valid, 0);

    // Simultaneous push and pop at occupancy 2.
    btb_en = 1'b0;
    drive(1, 0, 32'h100, 0, 32'h180, 0, 32'h180);
    tick();
    drive(1, 0, 32'h104, 0, 32'h180, 0, 32'h180);
    tick();
    btb_en = 1'b1;
    drive(1, 0, 32'h108, 0, 32'h180, 0, 32'h180);
    tick();
    idle();
    btb_en = 1'b0;
    chk("t4_head", btb_update.pc, 32'h104);
    chk("t4_bc", branch_count, 9);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 32'h200 + 32'h4 * i, 1, 32'h300, 0, 32'h0);
      tick();
    end
    idle();
    chk("t4_nc_bc", branch_count, 9);
    chk("t4_nc_head", btb_update.pc, 32'h104);
    btb_en = 1'b1;
    tick();
    chk("t4_second", btb_update.pc, 32'h108);
    tick();
    chk("t4_empty", btb_update.valid, 0);

    // JAL target mispredict at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC, 0, 32'h100, 1, 32'h0);
    tick();
    idle();
    chk("t5_rv", redirect_valid, 1);
    chk("t5_rpc", redirect_pc, 32'h100);
    chk("t5_mc", mispred_count, 2);
    chk("t5_bc", branch_count, 10);
    tick();

    // Asynchronous reset with three entries queued.
    btb_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h300 + 32'h4 * i, 1, 32'h900, 1, 32'h900);
      tick();
    end
    idle();
    btb_en = 1'b1;
    chk("t6_pre_valid", btb_update.valid, 1);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", btb_update.valid, 0);
    chk("t6_async_ready", commit_ready, 1);
    @(negedge clk);
    #3;
    rst = 1'b1;
    tick();
    chk("t6_bc", branch_count, 0);
    chk("t6_mc", mispred_count, 0);
    chk("t6_valid", btb_update.valid, 0);
    chk("t6_rv", redirect_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
